// File: rtl/comp_serial_msb.sv
// comp_serial_msb: nibble-serial unsigned magnitude comparator.
// Walks two WIDTH-bit operands MSB-first, one nibble per clock, behind a
// start/busy/done handshake. The first differing nibble decides the result.
// Optional feature macro: CMP_EARLY_EXIT_EN. When defined, the scan stops on
// the first differing nibble. When undefined, all NIB nibbles are always scanned.
// WIDTH must be a multiple of 4 and at least 8.
module comp_serial_msb #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned NIB = WIDTH / 4,
    localparam int unsigned CW = $clog2(NIB) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_a_lt_b,
    output logic             o_a_eq_b,
    output logic             o_a_gt_b,
    output logic [CW-1:0]    o_nib_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [CW-1:0] NIB_C = CW'(NIB);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [CW-1:0]    r_cnt;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic             w_lt_nxt;
    logic             w_eq_nxt;
    logic             w_gt_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_accept;

    // Evaluate the current top nibble and decide whether this edge ends the scan.
    always_comb begin
        w_nib_a   = r_sa[WIDTH-1 -: 4];
        w_nib_b   = r_sb[WIDTH-1 -: 4];
        // Once a difference has been seen the flags are frozen.
        w_lt_nxt  = r_eq ? (w_nib_a < w_nib_b) : r_lt;
        w_gt_nxt  = r_eq ? (w_nib_a > w_nib_b) : r_gt;
        w_eq_nxt  = r_eq && (w_nib_a == w_nib_b);
        w_cnt_nxt = r_cnt + 1'b1;
`ifdef CMP_EARLY_EXIT_EN
        w_last    = (w_cnt_nxt == NIB_C) || (r_eq && (w_nib_a != w_nib_b));
`else
        w_last    = (w_cnt_nxt == NIB_C);
`endif
        // start is only honoured outside COMPARE (IDLE or DONE).
        w_accept  = i_start && (r_state != S_COMPARE);
    end

    // Handshake decode from the state register.
    always_comb begin
        o_busy = (r_state == S_COMPARE);
        o_done = (r_state == S_DONE);
    end

    // State, shift registers, working flags and registered results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b1;
            r_gt        <= 1'b0;
            r_cnt       <= '0;
            o_a_lt_b    <= 1'b0;
            o_a_eq_b    <= 1'b1;
            o_a_gt_b    <= 1'b0;
            o_nib_count <= '0;
        end else begin
            case (r_state)
                S_COMPARE: begin
                    r_sa  <= r_sa << 4;
                    r_sb  <= r_sb << 4;
                    r_lt  <= w_lt_nxt;
                    r_eq  <= w_eq_nxt;
                    r_gt  <= w_gt_nxt;
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        // Results move only here, so they never glitch mid-scan.
                        o_a_lt_b    <= w_lt_nxt;
                        o_a_eq_b    <= w_eq_nxt;
                        o_a_gt_b    <= w_gt_nxt;
                        o_nib_count <= w_cnt_nxt;
                    end
                end
                default: begin
                    // IDLE, DONE (and any unused encoding) share accept logic.
                    if (w_accept) begin
                        r_state <= S_COMPARE;
                        r_sa    <= i_a;
                        r_sb    <= i_b;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_gt    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_serial_msb.sv
// Bench for comp_serial_msb (WIDTH=16). Works with or without CMP_EARLY_EXIT_EN.
module tb_comp_serial_msb;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        lt;
    logic        eq;
    logic        gt;
    logic [2:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;

    comp_serial_msb #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_a         (a),
        .i_b         (b),
        .o_busy      (busy),
        .o_done      (done),
        .o_a_lt_b    (lt),
        .o_a_eq_b    (eq),
        .o_a_gt_b    (gt),
        .o_nib_count (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: cycles / nibbles examined, from the operands directly.
    function automatic int ref_cnt(input logic [15:0] x, input logic [15:0] y);
`ifdef CMP_EARLY_EXIT_EN
        for (int k = 1; k <= NIB; k++) begin
            if (((x >> (4 * (NIB - k))) & 16'hF) != ((y >> (4 * (NIB - k))) & 16'hF))
                return k;
        end
`endif
        return NIB;
    endfunction

    // Drives one operation; reports latency, results and whether busy or the
    // results misbehaved while the scan was in progress.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, output int lat,
                          output logic [2:0] res, output logic [2:0] nc,
                          output logic bad_hold);
        logic [2:0] prev;
        int k;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        prev = {lt, eq, gt};
        bad_hold = !busy || done;
        lat = -1;
        k = 0;
        while (lat < 0 && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (done) lat = k;
            else if (!busy || {lt, eq, gt} != prev) bad_hold = 1'b1;
        end
        res = {lt, eq, gt};
        nc = cnt;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        n_tests++;
        if ({busy, done, lt, eq, gt, cnt} !== {5'b00010, 3'd0}) begin
            n_fail++;
            $display("FAIL reset: busy/done/lt/eq/gt/cnt=%b required 00010000",
                     {busy, done, lt, eq, gt, cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic [15:0] x, input logic [15:0] y);
        int lat;
        logic [2:0] res;
        logic [2:0] nc;
        logic bad;
        logic [2:0] exp_res;
        int exp_c;
        exp_res = {x < y, x == y, x > y};
        exp_c = ref_cnt(x, y);
        run_op(x, y, lat, res, nc, bad);
        n_tests++;
        if (res !== exp_res || nc !== 3'(exp_c) || lat != exp_c || bad) begin
            n_fail++;
            $display("FAIL %s a=%h b=%h: lt/eq/gt=%b cnt=%0d lat=%0d hold_err=%b required %b cnt=%0d lat=%0d hold_err=0",
                     name, x, y, res, nc, lat, bad, exp_res, exp_c, exp_c);
        end
    endtask

    task automatic test_directed;
        check_op("equal_5555", 16'h5555, 16'h5555);
        check_op("gt_msb", 16'h8000, 16'h7FFF);
        check_op("lt_lsb", 16'h1234, 16'h1235);
        check_op("lt_3f_41", 16'h3F00, 16'h4100);
        check_op("zero_zero", 16'h0000, 16'h0000);
        check_op("max_vs_max_m1", 16'hFFFF, 16'hFFFE);
    endtask

    task automatic test_random;
        logic [15:0] x;
        logic [15:0] y;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ (16'h1 << $urandom_range(0, 15));
                default: y = 16'($urandom);
            endcase
            check_op("random", x, y);
        end
    endtask

    task automatic test_ignore_busy;
        int dones;
        int first;
        @(negedge clk);
        a = 16'h00FF; b = 16'hFF00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Request during busy must be ignored.
        a = 16'hAAAA; b = 16'hAAAA; start = 1'b1;
        dones = 0; first = -1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = k;
                n_tests++;
                if ({lt, eq, gt} !== 3'b100 || cnt !== 3'(ref_cnt(16'h00FF, 16'hFF00))) begin
                    n_fail++;
                    $display("FAIL ignore_busy_result: lt/eq/gt=%b cnt=%0d required 100 cnt=%0d",
                             {lt, eq, gt}, cnt, ref_cnt(16'h00FF, 16'hFF00));
                end
            end
        end
        n_tests++;
        if (dones != 1 || first != ref_cnt(16'h00FF, 16'hFF00)) begin
            n_fail++;
            $display("FAIL ignore_busy_dones: count=%0d at=%0d required 1 at=%0d",
                     dones, first, ref_cnt(16'h00FF, 16'hFF00));
        end
    endtask

    task automatic test_back_to_back;
        int l;
        int dones;
        int last;
        int bad_gap;
        l = ref_cnt(16'hFFFF, 16'h0000);
        dones = 0; last = -1; bad_gap = 0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        for (int k = 1; k <= 3 * (NIB + 1) + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                if (last < 0 ? (k != 1 + l) : (k - last != l + 1)) bad_gap++;
                last = k;
                n_tests++;
                if ({lt, eq, gt} !== 3'b001 || cnt !== 3'(l)) begin
                    n_fail++;
                    $display("FAIL back_to_back_result: lt/eq/gt=%b cnt=%0d required 001 cnt=%0d",
                             {lt, eq, gt}, cnt, l);
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (dones < 3 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL back_to_back_rate: pulses=%0d bad_gaps=%0d required >=3 and 0 (period %0d)",
                     dones, bad_gap, l + 1);
        end
        repeat (NIB + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int spurious;
        @(negedge clk);
        a = 16'hCDEF; b = 16'hCDEE; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, lt, eq, gt, cnt} !== {5'b00010, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: busy/done/lt/eq/gt/cnt=%b required 00010000",
                     {busy, done, lt, eq, gt, cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        n_tests++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: busy/done seen %0d cycles required 0", spurious);
        end
        check_op("after_reset", 16'hCDEF, 16'hCDEE);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
